ame_matrix_builder: RTL and testbench

- Upstream feeder of the affine motion-estimation equation solver.
- Accepts a stream of per-pixel gradient/difference samples for one block and builds the symmetric normal-equation system: coefficient matrix A plus right-hand side B in column 6.
- Hands the matrix to the solver with a one-cycle comp_init_o pulse, then holds it until the solver reports done.

---
 rtl/ame_matrix_builder.sv | 158 +++++++++++++++
 tb/tb_ame_matrix_builder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_matrix_builder.sv
// Builds the symmetric affine normal-equation system (A | B) from one block's gradient samples.
// Define AME_DIFF_SCALE_EN to pre-scale the right-hand side B by 8 for the solver's fixed-point alignment.
module ame_matrix_builder #(
    parameter int COMP_DATA_BITS = 64,
    parameter int GRAD_BITS      = 16,
    parameter int DIFF_BITS      = 16,
    parameter int POS_BITS       = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  blk_init_i,
    input  logic                                  affine_param6_i,
    input  logic                                  smp_valid_i,
    output logic                                  smp_ready_o,
    input  logic                                  smp_last_i,
    input  logic [GRAD_BITS-1:0]                  gx_i,
    input  logic [GRAD_BITS-1:0]                  gy_i,
    input  logic [POS_BITS-1:0]                   pos_x_i,
    input  logic [POS_BITS-1:0]                   pos_y_i,
    input  logic [DIFF_BITS-1:0]                  diff_i,
    output logic                                  affine_param6_o,
    output logic                                  comp_init_o,
    input  logic                                  comp_done_i,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]   comp_data_o
);

    // Wide enough for x*gx + y*gy without overflow.
    localparam int CW   = GRAD_BITS + POS_BITS + 1;
    localparam int NTRI = 21;

    typedef enum logic [2:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_ISSUE, ST_WAIT} state_t;

    state_t state, state_next;

    logic param6;
    logic accept;
    logic v1, v2;

    logic signed [CW-1:0]             gx, gy, px, py;
    logic signed [CW-1:0]             coef    [6];
    logic signed [CW-1:0]             s1_coef [6];
    logic signed [DIFF_BITS-1:0]      s1_diff;
    logic signed [COMP_DATA_BITS-1:0] prod_a  [NTRI];
    logic signed [COMP_DATA_BITS-1:0] prod_b  [6];
    logic signed [COMP_DATA_BITS-1:0] acc_a   [NTRI];
    logic signed [COMP_DATA_BITS-1:0] acc_b   [6];

    // Packed index of upper-triangle element (i, j), j >= i, row-major.
    function automatic int tri_idx(input int i, input int j);
        return i * 6 - (i * (i - 1)) / 2 + (j - i);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (blk_init_i)             state_next = ST_ACCUM;
            ST_ACCUM: if (accept && smp_last_i)   state_next = ST_DRAIN;
            ST_DRAIN: if (!v1 && !v2)             state_next = ST_ISSUE;
            ST_ISSUE:                             state_next = ST_WAIT;
            ST_WAIT:  if (comp_done_i)            state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        smp_ready_o = (state == ST_ACCUM);
        comp_init_o = (state == ST_ISSUE);
    end

    assign accept          = smp_valid_i && smp_ready_o;
    assign affine_param6_o = param6;

    assign gx = CW'($signed(gx_i));
    assign gy = CW'($signed(gy_i));
    assign px = CW'($signed(pos_x_i));
    assign py = CW'($signed(pos_y_i));

    always_comb begin
        // NOTE: every coefficient gets a default first, so no path leaves one unassigned (no latch).
        for (int k = 0; k < 6; k++) coef[k] = '0;
        if (param6) begin
            coef[0] = gx;
            coef[1] = px * gx;
            coef[2] = gy;
            coef[3] = py * gy;
            coef[4] = px * gy;
            coef[5] = py * gx;
        end else begin
            coef[2] = gx;
            coef[3] = px * gx + py * gy;
            coef[4] = gy;
            coef[5] = py * gx - px * gy;
        end
    end

    // NOTE: datapath stages carry no reset; v1/v2 qualify them, so stale contents are never accumulated.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_coef <= coef;
            s1_diff <= $signed(diff_i);
        end
        if (v1) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    if (j >= i)
                        prod_a[tri_idx(i, j)] <= COMP_DATA_BITS'(s1_coef[i]) * COMP_DATA_BITS'(s1_coef[j]);
                end
`ifdef AME_DIFF_SCALE_EN
                prod_b[i] <= (COMP_DATA_BITS'(s1_coef[i]) * COMP_DATA_BITS'(s1_diff)) <<< 3;
`else
                prod_b[i] <= COMP_DATA_BITS'(s1_coef[i]) * COMP_DATA_BITS'(s1_diff);
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            param6 <= 1'b0;
            for (int k = 0; k < NTRI; k++) acc_a[k] <= '0;
            for (int k = 0; k < 6; k++)    acc_b[k] <= '0;
        end else if (state == ST_IDLE && blk_init_i) begin
            param6 <= affine_param6_i;
            for (int k = 0; k < NTRI; k++) acc_a[k] <= '0;
            for (int k = 0; k < 6; k++)    acc_b[k] <= '0;
        end else if (v2) begin
            for (int k = 0; k < NTRI; k++) acc_a[k] <= acc_a[k] + prod_a[k];
            for (int k = 0; k < 6; k++)    acc_b[k] <= acc_b[k] + prod_b[k];
        end
    end

    // Lower triangle mirrors the stored upper triangle.
    always_comb begin
        comp_data_o = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                comp_data_o[i][j] = (j >= i) ? acc_a[tri_idx(i, j)] : acc_a[tri_idx(j, i)];
            end
            comp_data_o[i][6] = acc_b[i];
        end
    end

endmodule

// File: tb/tb_ame_matrix_builder.sv
// Self-checking bench for ame_matrix_builder: directed cases plus random blocks against a matrix model.
module tb_ame_matrix_builder;

`ifdef AME_DIFF_SCALE_EN
    localparam longint B_SCALE = 8;
`else
    localparam longint B_SCALE = 1;
`endif

    logic clk_i           = 1'b0;
    logic rst_n_i         = 1'b0;
    logic blk_init_i      = 1'b0;
    logic affine_param6_i = 1'b0;
    logic smp_valid_i     = 1'b0;
    logic smp_last_i      = 1'b0;
    logic comp_done_i     = 1'b0;
    logic [15:0] gx_i     = '0;
    logic [15:0] gy_i     = '0;
    logic [15:0] diff_i   = '0;
    logic [7:0]  pos_x_i  = '0;
    logic [7:0]  pos_y_i  = '0;
    logic smp_ready_o;
    logic affine_param6_o;
    logic comp_init_o;
    logic [5:0][6:0][63:0] comp_data_o;

    int     n_asserts   = 0;
    int     n_fail      = 0;
    int     init_pulses = 0;
    int     pulse_base  = 0;
    bit     model_p6    = 1'b0;
    longint exp_m [6][7];

    ame_matrix_builder dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .blk_init_i      (blk_init_i),
        .affine_param6_i (affine_param6_i),
        .smp_valid_i     (smp_valid_i),
        .smp_ready_o     (smp_ready_o),
        .smp_last_i      (smp_last_i),
        .gx_i            (gx_i),
        .gy_i            (gy_i),
        .pos_x_i         (pos_x_i),
        .pos_y_i         (pos_y_i),
        .diff_i          (diff_i),
        .affine_param6_o (affine_param6_o),
        .comp_init_o     (comp_init_o),
        .comp_done_i     (comp_done_i),
        .comp_data_o     (comp_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (comp_init_o === 1'b1) init_pulses++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic check_matrix(input string tag);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                check($sformatf("%s_m%0d%0d", tag, i, j), comp_data_o[i][j], exp_m[i][j]);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                exp_m[i][j] = 0;
    endfunction

    // Normal equations straight from the coefficient definitions: A += c c^T, B += c*diff.
    function automatic void model_add(input bit p6, input longint gx, input longint gy,
                                      input longint x, input longint y, input longint d);
        longint c [6];
        if (p6) begin
            c[0] = gx;     c[1] = x * gx; c[2] = gy;
            c[3] = y * gy; c[4] = x * gy; c[5] = y * gx;
        end else begin
            c[0] = 0;      c[1] = 0;               c[2] = gx;
            c[3] = x * gx + y * gy;  c[4] = gy;    c[5] = y * gx - x * gy;
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) exp_m[i][j] += c[i] * c[j];
            exp_m[i][6] += c[i] * d * B_SCALE;
        end
    endfunction

    function automatic int rand_grad();
        if ($urandom_range(7) == 0) return ($urandom_range(1) == 1) ? 32767 : -32768;
        return int'($urandom_range(65535)) - 32768;
    endfunction

    function automatic int rand_pos();
        if ($urandom_range(7) == 0) return ($urandom_range(1) == 1) ? 127 : -128;
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic start_block(input bit p6);
        blk_init_i      = 1'b1;
        affine_param6_i = p6;
        @(posedge clk_i); #1;
        blk_init_i      = 1'b0;
        affine_param6_i = ~p6;
        model_clear();
        model_p6   = p6;
        pulse_base = init_pulses;
        check("param6_latched", affine_param6_o, p6);
        check("ready_after_init", smp_ready_o, 1);
        check_matrix("cleared");
    endtask

    task automatic push(input bit valid, input int gx, input int gy, input int x, input int y,
                        input int d, input bit last, input bit noise);
        bit rdy;
        smp_valid_i = valid;
        gx_i        = 16'(gx);
        gy_i        = 16'(gy);
        pos_x_i     = 8'(x);
        pos_y_i     = 8'(y);
        diff_i      = 16'(d);
        smp_last_i  = last;
        blk_init_i  = noise && ($urandom_range(3) == 0);
        comp_done_i = noise && ($urandom_range(3) == 0);
        rdy = smp_ready_o;
        check("ready_in_accum", rdy, 1);
        @(posedge clk_i); #1;
        if (valid && rdy) model_add(model_p6, gx, gy, x, y, d);
        smp_valid_i = 1'b0;
        smp_last_i  = 1'b0;
        blk_init_i  = 1'b0;
        comp_done_i = 1'b0;
    endtask

    // Entered one step after the edge that accepted the last sample (cycle t+1).
    task automatic wait_issue(input string tag);
        int n;
        n = 1;
        while (comp_init_o !== 1'b1 && n < 16) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_init_latency"}, n, 4);
        check({tag, "_ready_at_issue"}, smp_ready_o, 0);
        check_matrix(tag);
    endtask

    task automatic release_block(input string tag, input int hold);
        @(posedge clk_i); #1;
        check({tag, "_init_one_cycle"}, comp_init_o, 0);
        for (int k = 0; k < hold; k++) begin
            blk_init_i = (k == 0);
            @(posedge clk_i); #1;
            blk_init_i = 1'b0;
            check({tag, "_ready_in_wait"}, smp_ready_o, 0);
            check({tag, "_init_in_wait"}, comp_init_o, 0);
        end
        check_matrix({tag, "_wait"});
        comp_done_i = 1'b1;
        @(posedge clk_i); #1;
        comp_done_i = 1'b0;
        check({tag, "_ready_idle"}, smp_ready_o, 0);
        check({tag, "_pulse_count"}, init_pulses - pulse_base, 1);
        check_matrix({tag, "_idle"});
    endtask

    initial begin
        bit p6;
        int ns;
        int p0;

        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", smp_ready_o, 0);
        check("rst_init", comp_init_o, 0);
        check("rst_param6", affine_param6_o, 0);
        check_matrix("rst");
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // 6-parameter, single sample
        start_block(1'b1);
        push(1'b1, 2, 3, 1, 2, 5, 1'b1, 1'b0);
        wait_issue("p6_one");
        check("p6_one_A00", comp_data_o[0][0], 64'd4);
        check("p6_one_A01", comp_data_o[0][1], 64'd4);
        check("p6_one_A10", comp_data_o[1][0], 64'd4);
        check("p6_one_A33", comp_data_o[3][3], 64'd36);
        check("p6_one_A35", comp_data_o[3][5], 64'd24);
        check("p6_one_A53", comp_data_o[5][3], 64'd24);
        check("p6_one_B0", comp_data_o[0][6], 64'(10 * B_SCALE));
        check("p6_one_B3", comp_data_o[3][6], 64'(30 * B_SCALE));
        release_block("p6_one", 2);

        // 4-parameter, same sample
        start_block(1'b0);
        push(1'b1, 2, 3, 1, 2, 5, 1'b1, 1'b0);
        wait_issue("p4_one");
        check("p4_one_A22", comp_data_o[2][2], 64'd4);
        check("p4_one_A33", comp_data_o[3][3], 64'd64);
        check("p4_one_A44", comp_data_o[4][4], 64'd9);
        check("p4_one_A55", comp_data_o[5][5], 64'd1);
        check("p4_one_A34", comp_data_o[3][4], 64'd24);
        check("p4_one_A43", comp_data_o[4][3], 64'd24);
        check("p4_one_A02", comp_data_o[0][2], 64'd0);
        check("p4_one_A31", comp_data_o[3][1], 64'd0);
        check("p4_one_B3", comp_data_o[3][6], 64'(40 * B_SCALE));
        check("p4_one_B5", comp_data_o[5][6], 64'(5 * B_SCALE));
        release_block("p4_one", 1);

        // 6-parameter, two mirrored samples with negative operands
        start_block(1'b1);
        push(1'b1, -1, 0, -3, 0, 7, 1'b0, 1'b0);
        push(1'b1, 1, 0, 3, 0, 7, 1'b1, 1'b0);
        wait_issue("p6_two");
        check("p6_two_A00", comp_data_o[0][0], 64'd2);
        check("p6_two_A11", comp_data_o[1][1], 64'd18);
        check("p6_two_B0", comp_data_o[0][6], 64'd0);
        check("p6_two_B1", comp_data_o[1][6], 64'(42 * B_SCALE));
        release_block("p6_two", 3);

        // valid toggling 1,0,1 with a stray last on the idle cycle
        start_block(1'b1);
        push(1'b1, -5, 4, 3, -2, -9, 1'b0, 1'b0);
        push(1'b0, 100, 100, 10, 10, 100, 1'b1, 1'b0);
        push(1'b1, 7, -6, -4, 5, 11, 1'b1, 1'b0);
        wait_issue("toggle");
        release_block("toggle", 1);

        // Reset in the middle of accumulation
        start_block(1'b1);
        for (int s = 0; s < 3; s++)
            push(1'b1, rand_grad(), rand_grad(), rand_pos(), rand_pos(), rand_grad(), 1'b0, 1'b0);
        #3 rst_n_i = 1'b0;
        #1;
        model_clear();
        p0 = init_pulses;
        check("arst_ready", smp_ready_o, 0);
        check("arst_init", comp_init_o, 0);
        check("arst_param6", affine_param6_o, 0);
        check_matrix("arst");
        repeat (3) @(posedge clk_i);
        #4 rst_n_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        check("arst_no_init_pulse", init_pulses - p0, 0);
        check("arst_ready_idle", smp_ready_o, 0);
        start_block(1'b0);
        push(1'b1, 2, 3, 1, 2, 5, 1'b1, 1'b0);
        wait_issue("after_rst");
        release_block("after_rst", 1);

        // Random blocks with stray control inputs and valid gaps
        for (int b = 0; b < 12; b++) begin
            p6 = 1'($urandom_range(1));
            ns = int'($urandom_range(6, 1));
            start_block(p6);
            for (int s = 0; s < ns; s++) begin
                for (int g = 0; g < 2; g++)
                    if ($urandom_range(3) == 0)
                        push(1'b0, rand_grad(), rand_grad(), rand_pos(), rand_pos(), rand_grad(),
                             1'($urandom_range(1)), 1'b1);
                push(1'b1, rand_grad(), rand_grad(), rand_pos(), rand_pos(), rand_grad(),
                     s == ns - 1, 1'b1);
            end
            wait_issue($sformatf("rnd%0d", b));
            release_block($sformatf("rnd%0d", b), int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
